uart_receiving: RTL and testbench

UART_RECEIVING -- requirements
Module: uart_receiving

---
 rtl/uart_receiving.sv | 192 +++++++++++++++++++
 tb/tb_uart_receiving.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiving.sv
// uart_receiving
//   8N1 UART receiver with a first-word-fall-through receive FIFO.
//   rx is synchronized by two flops. A single down-counter times the half
//   bit that ends in the middle of the start bit and the full bit periods
//   that follow. Each bit is sampled once, in the middle of that bit.
//
// Ports
//   clk           system clock; all logic uses the rising edge
//   reset         asynchronous, active-low reset
//   rx            serial line, idle high, asynchronous to clk
//   data_out      byte at the FIFO head (0 when the FIFO is empty)
//   data_valid    high while the FIFO is non-empty
//   data_ready    the head is popped on a cycle where this and data_valid are high
//   fifo_count    number of stored bytes, 0..fifo_depth
//   framing_error one-cycle pulse when the stop bit is sampled low
//   overrun       sticky; set when a byte is dropped because the FIFO is full
//   clear         synchronous clear of overrun (a new overrun in the same cycle wins)
module uart_receiving #(
   parameter int clk_freq   = 1_000_000,
   parameter int baud_rate  = 9600,
   parameter int fifo_depth = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic [8:0] fifo_count,
   output logic       framing_error,
   output logic       overrun,
   input  logic       clear
);

   localparam int div   = clk_freq / baud_rate;
   localparam int half  = div / 2;
   localparam int cnt_w = (div > 1) ? $clog2(div) : 1;
   localparam int aw    = $clog2(fifo_depth);

   localparam logic [cnt_w-1:0] half_m1 = cnt_w'(half - 1);
   localparam logic [cnt_w-1:0] div_m1  = cnt_w'(div - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   // ---------------- rx synchronizer ----------------
   // Both flops reset to the idle level, so reset does not look like a start bit.
   logic sync1, rx_sync;

   // NOTE: sequential state uses non-blocking assignments only. Every flop
   // then samples its value from before the edge, whatever the order of the
   // statements.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         sync1   <= rx;
         rx_sync <= sync1;
      end
   end

   // ---------------- receive FSM ----------------
   state_t           state, state_next;
   logic [cnt_w-1:0] cnt, cnt_next;
   logic [7:0]       shift, shift_next;
   logic [2:0]       bit_cnt, bit_next;
   logic             push, fe_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         shift         <= '0;
         bit_cnt       <= '0;
         framing_error <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         shift         <= shift_next;
         bit_cnt       <= bit_next;
         framing_error <= fe_next;
      end
   end

   // NOTE: every output of this block gets a default before the case
   // statement. No path through the block leaves a value unassigned, so no
   // latch is inferred.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      shift_next = shift;
      bit_next   = bit_cnt;
      push       = 1'b0;
      fe_next    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!rx_sync) begin
               state_next = S_START;
               cnt_next   = half_m1;
            end
         end
         S_START: begin
            if (cnt == '0) begin
               // If the line is high again in mid start bit, it was a glitch.
               if (!rx_sync) begin
                  state_next = S_DATA;
                  cnt_next   = div_m1;
                  bit_next   = 3'd0;
               end else begin
                  state_next = S_IDLE;
               end
            end else begin
               cnt_next = cnt - cnt_w'(1);
            end
         end
         S_DATA: begin
            if (cnt == '0) begin
               // LSB arrives first: shift right so the first bit ends in bit 0.
               shift_next = {rx_sync, shift[7:1]};
               cnt_next   = div_m1;
               bit_next   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_next = S_STOP;
            end else begin
               cnt_next = cnt - cnt_w'(1);
            end
         end
         S_STOP: begin
            if (cnt == '0) begin
               if (rx_sync) begin
                  push       = 1'b1;
                  state_next = S_IDLE;
               end else begin
                  fe_next    = 1'b1;
                  state_next = S_WAIT_IDLE;
               end
            end else begin
               cnt_next = cnt - cnt_w'(1);
            end
         end
         S_WAIT_IDLE: begin
            if (rx_sync) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- receive FIFO ----------------
   logic [7:0]    mem [fifo_depth];
   logic [aw-1:0] wptr, rptr;
   logic [8:0]    count;
   logic          pop, full, do_push;

   assign data_valid = (count != 9'd0);
   assign pop        = data_valid & data_ready;
   assign full       = (count == 9'(fifo_depth));
   // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
   assign do_push    = push & (~full | pop);
   assign data_out   = data_valid ? mem[rptr] : 8'h00;
   assign fifo_count = count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
         unique case ({do_push, pop})
            2'b10:   count <= count + 9'd1;
            2'b01:   count <= count - 9'd1;
            default: count <= count;
         endcase
         if (push && full && !pop) overrun <= 1'b1;
         else if (clear)           overrun <= 1'b0;
      end
   end

   // NOTE: the storage array has no reset. An entry is only read after it
   // has been written, and data_out is forced to 0 while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= shift;
   end

endmodule

// File: tb/tb_uart_receiving.sv
// tb_uart_receiving
//   Directed bench for uart_receiving at clk_freq=2 MHz, baud_rate=9600.
//   With these values one bit lasts 208 clocks. The bench drives frames on
//   rx from the falling clock edge and checks outputs on falling edges.
module tb_uart_receiving;

   localparam int div = 208;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx = 1'b1;
   logic       data_ready = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic [8:0] fifo_count;
   logic       framing_error;
   logic       overrun;

   int total = 0;
   int bad = 0;
   int fe_pulses = 0;
   int fe_base = 0;
   int lat = 0;

   uart_receiving #(
      .clk_freq  (2_000_000),
      .baud_rate (9600),
      .fifo_depth(8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .data_ready   (data_ready),
      .fifo_count   (fifo_count),
      .framing_error(framing_error),
      .overrun      (overrun),
      .clear        (clear)
   );

   always #5 clk = ~clk;

   // Counts the cycles in which framing_error is high. A single pulse adds exactly 1.
   always @(negedge clk) if (framing_error === 1'b1) fe_pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (div) @(negedge clk);
      end
      rx = stop;
      repeat (div) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] exp);
      check({tag, "_valid"}, 32'(data_valid), 32'd1);
      check({tag, "_data"}, 32'(data_out), 32'(exp));
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
   endtask

   initial begin
      // ---- reset state ----
      repeat (5) @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_valid", 32'(data_valid), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_fe", 32'(framing_error), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b1;
      repeat (50) @(negedge clk);

      // ---- data_ready while empty has no effect ----
      data_ready = 1'b1;
      repeat (3) @(negedge clk);
      data_ready = 1'b0;
      check("empty_pop_count", 32'(fifo_count), 32'd0);
      check("empty_pop_valid", 32'(data_valid), 32'd0);

      // ---- frame 0x41 with latency ----
      // Falling edge, plus 2 sync flops, plus HALF, plus 9*DIV puts the stop
      // sample at about clock 1978. data_valid is seen on the falling edge after it.
      lat = 0;
      fork
         send_frame(8'h41, 1'b1);
         begin
            while (data_valid !== 1'b1 && lat < 3000) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      check("lat_0x41_window", 32'(lat >= 1970 && lat <= 1990), 32'd1);
      check("rx41_count", 32'(fifo_count), 32'd1);
      pop_expect("rx41", 8'h41);
      check("rx41_pop_valid", 32'(data_valid), 32'd0);
      check("rx41_pop_count", 32'(fifo_count), 32'd0);
      check("rx41_pop_data", 32'(data_out), 32'h0);

      // ---- framing error on 0x55, then 0xA3 ----
      fe_base = fe_pulses;
      send_frame(8'h55, 1'b0);
      repeat (20) @(negedge clk);
      check("fe_single_pulse", 32'(fe_pulses - fe_base), 32'd1);
      check("fe_count", 32'(fifo_count), 32'd0);
      send_frame(8'hA3, 1'b1);
      repeat (20) @(negedge clk);
      check("rxA3_count", 32'(fifo_count), 32'd1);
      pop_expect("rxA3", 8'hA3);

      // ---- start-bit glitch rejection ----
      fe_base = fe_pulses;
      rx = 1'b0;
      repeat (50) @(negedge clk);
      rx = 1'b1;
      repeat (300) @(negedge clk);
      check("glitch_count", 32'(fifo_count), 32'd0);
      check("glitch_fe", 32'(fe_pulses - fe_base), 32'd0);
      send_frame(8'h12, 1'b1);
      repeat (20) @(negedge clk);
      check("rx12_count", 32'(fifo_count), 32'd1);
      pop_expect("rx12", 8'h12);

      // ---- fill FIFO and overrun ----
      for (int i = 1; i <= 8; i++) begin
         send_frame(8'(i), 1'b1);
         repeat (20) @(negedge clk);
      end
      check("fill8_count", 32'(fifo_count), 32'd8);
      check("fill8_overrun", 32'(overrun), 32'd0);
      send_frame(8'h09, 1'b1);
      repeat (20) @(negedge clk);
      check("ovr_count", 32'(fifo_count), 32'd8);
      check("ovr_flag", 32'(overrun), 32'd1);
      check("ovr_head", 32'(data_out), 32'h01);
      for (int i = 1; i <= 8; i++) pop_expect("ovr_pop", 8'(i));
      check("ovr_drain_count", 32'(fifo_count), 32'd0);
      check("ovr_sticky", 32'(overrun), 32'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'd0);

      // ---- push and pop in the same cycle while full ----
      for (int i = 1; i <= 8; i++) begin
         send_frame(8'(i), 1'b1);
         repeat (20) @(negedge clk);
      end
      check("full2_count", 32'(fifo_count), 32'd8);
      fork
         send_frame(8'h09, 1'b1);
         begin
            // The push edge is clock 1978 after rx falls. Hold data_ready high only across that edge.
            repeat (1978) @(negedge clk);
            data_ready = 1'b1;
            @(negedge clk);
            data_ready = 1'b0;
         end
      join
      repeat (20) @(negedge clk);
      check("pushpop_overrun", 32'(overrun), 32'd0);
      check("pushpop_count", 32'(fifo_count), 32'd8);
      for (int i = 2; i <= 9; i++) pop_expect("pushpop_pop", 8'(i));
      check("pushpop_drain", 32'(fifo_count), 32'd0);

      // ---- reset mid-frame ----
      send_frame(8'h66, 1'b1);
      repeat (20) @(negedge clk);
      check("pre_rst_count", 32'(fifo_count), 32'd1);
      fe_base = fe_pulses;
      rx = 1'b0;                          // start bit of 0x7E
      repeat (div) @(negedge clk);
      rx = 1'b0;                          // bit0
      repeat (div) @(negedge clk);
      rx = 1'b1;                          // bit1
      repeat (div) @(negedge clk);
      rx = 1'b1;                          // bit2
      repeat (div) @(negedge clk);
      rx = 1'b1;                          // bit3, interrupted by reset
      repeat (100) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rst_data_out", 32'(data_out), 32'h0);
      check("mid_rst_valid", 32'(data_valid), 32'd0);
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_fe", 32'(framing_error), 32'd0);
      check("mid_rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b1;
      repeat (300) @(negedge clk);
      check("post_rst_idle_count", 32'(fifo_count), 32'd0);
      send_frame(8'h3C, 1'b1);
      repeat (20) @(negedge clk);
      check("rx3C_count", 32'(fifo_count), 32'd1);
      check("rx3C_fe", 32'(fe_pulses - fe_base), 32'd0);
      pop_expect("rx3C", 8'h3C);
      check("rx3C_drain", 32'(fifo_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
